// File: rtl/gamma_pkg.sv
// Shared constants, types and helpers for the gamma LUT mapper.
package gamma_pkg;

  localparam int GAMMA_PIPE_LAT = 2;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CH     = 3;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/gamma_lut_bank.sv
// One channel's LUT storage: two banks of 2**DATA_W entries, simple dual-port,
// synchronous read. The bank select is the MSB of the flat RAM address.
module gamma_lut_bank
  import gamma_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rd_bank,
  input  logic [DATA_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** (DATA_W + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the RAM and its read register have no reset on purpose; LUT contents
  // must survive rst_n, and a reset port would stop the array mapping to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data_q <= mem_q[{rd_bank, rd_addr}];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gamma_lut_mapper.sv
// Two-stage per-channel LUT mapper with active/shadow banks that swap only at
// a frame start, so a frame is never mapped by two different curves.
module gamma_lut_mapper
  import gamma_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int CH     = DEFAULT_CH,
  localparam int CH_W   = ch_w(CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 per_img_vsync,
  input  logic                 per_img_href,
  input  logic [CH*DATA_W-1:0] per_img_data,
  input  logic                 bypass,
  output logic                 post_img_vsync,
  output logic                 post_img_href,
  output logic [CH*DATA_W-1:0] post_img_data,
  input  logic                 lut_wr_en,
  input  logic [CH_W-1:0]      lut_wr_ch,
  input  logic [DATA_W-1:0]    lut_wr_addr,
  input  logic [DATA_W-1:0]    lut_wr_data,
  input  logic                 swap_req,
  output logic                 swap_pending,
  output logic                 bank_active
);

  logic                 vsync1_q, vsync1_d;
  logic                 href1_q, href1_d;
  logic                 byp1_q, byp1_d;
  logic [CH*DATA_W-1:0] raw1_q, raw1_d;
  logic                 vsync2_q, vsync2_d;
  logic                 href2_q, href2_d;
  logic [CH*DATA_W-1:0] data2_q, data2_d;
  swap_state_t          state_q, state_d;
  logic                 bank_q, bank_d;

  logic [CH*DATA_W-1:0] lut_rd;
  logic                 frame_start;
  logic                 wr_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    frame_start = per_img_vsync & ~vsync1_q;
    wr_valid    = lut_wr_en && (int'(lut_wr_ch) < CH);

    state_d = state_q;
    bank_d  = bank_q;
    // A request coinciding with the frame start swaps immediately.
    if (frame_start && (state_q == PENDING || swap_req)) begin
      bank_d  = ~bank_q;
      state_d = IDLE;
    end else if (swap_req) begin
      state_d = PENDING;
    end

    vsync1_d = per_img_vsync;
    href1_d  = per_img_href;
    byp1_d   = bypass;
    raw1_d   = per_img_data;

    vsync2_d = vsync1_q;
    href2_d  = href1_q;
    data2_d  = '0;
    if (href1_q) begin
      data2_d = byp1_q ? raw1_q : lut_rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync1_q <= 1'b0;
      href1_q  <= 1'b0;
      byp1_q   <= 1'b0;
      raw1_q   <= '0;
      vsync2_q <= 1'b0;
      href2_q  <= 1'b0;
      data2_q  <= '0;
      state_q  <= IDLE;
      bank_q   <= 1'b0;
    end else begin
      vsync1_q <= vsync1_d;
      href1_q  <= href1_d;
      byp1_q   <= byp1_d;
      raw1_q   <= raw1_d;
      vsync2_q <= vsync2_d;
      href2_q  <= href2_d;
      data2_q  <= data2_d;
      state_q  <= state_d;
      bank_q   <= bank_d;
    end
  end

  // Reads use the active bank; writes always go to the other one.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    gamma_lut_bank #(.DATA_W(DATA_W)) u_bank (
      .clk     (clk),
      .rd_bank (bank_q),
      .rd_addr (per_img_data[gi*DATA_W +: DATA_W]),
      .rd_data (lut_rd[gi*DATA_W +: DATA_W]),
      .wr_en   (wr_valid && (int'(lut_wr_ch) == gi)),
      .wr_bank (~bank_q),
      .wr_addr (lut_wr_addr),
      .wr_data (lut_wr_data)
    );
  end

  assign post_img_vsync = vsync2_q;
  assign post_img_href  = href2_q;
  assign post_img_data  = data2_q;
  assign swap_pending   = (state_q == PENDING);
  assign bank_active    = bank_q;

endmodule

// File: tb/tb_gamma_lut_mapper.sv
// Directed bench for gamma_lut_mapper: reset, latency, bank swapping, bypass,
// invalid-channel writes and mid-frame reset.
module tb_gamma_lut_mapper;

  localparam int DATA_W = 8;
  localparam int CH     = 3;
  localparam int CH_W   = 2;
  localparam int PW     = CH * DATA_W;

  typedef logic [PW-1:0] px_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              per_img_vsync, per_img_href, bypass;
  px_t               per_img_data;
  logic              post_img_vsync, post_img_href;
  px_t               post_img_data;
  logic              lut_wr_en;
  logic [CH_W-1:0]   lut_wr_ch;
  logic [DATA_W-1:0] lut_wr_addr, lut_wr_data;
  logic              swap_req, swap_pending, bank_active;

  int n_cmp = 0;
  int n_mis = 0;

  px_t  px [8];
  px_t  od [9];
  logic oh [9];

  always #5 clk = ~clk;

  gamma_lut_mapper #(.DATA_W(DATA_W), .CH(CH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_data   (per_img_data),
    .bypass         (bypass),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_data  (post_img_data),
    .lut_wr_en      (lut_wr_en),
    .lut_wr_ch      (lut_wr_ch),
    .lut_wr_addr    (lut_wr_addr),
    .lut_wr_data    (lut_wr_data),
    .swap_req       (swap_req),
    .swap_pending   (swap_pending),
    .bank_active    (bank_active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic vs);
    per_img_vsync = vs;
    per_img_href  = 1'b0;
    step();
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic load_lut(input bit inv);
    for (int c = 0; c < CH; c++) begin
      for (int a = 0; a < 256; a++) begin
        lut_wr_en   = 1'b1;
        lut_wr_ch   = CH_W'(c);
        lut_wr_addr = 8'(a);
        lut_wr_data = inv ? 8'(255 - a) : 8'(a);
        step();
      end
    end
    lut_wr_en = 1'b0;
  endtask

  // Sends px[0..n-1] as one line plus a href-low gap; od/oh[i] is the output for input slot i.
  task automatic send_line(input int n, input logic [7:0] mask);
    for (int j = 0; j <= n + 1; j++) begin
      per_img_href = (j < n);
      per_img_data = (j < n) ? px[j] : ((j == n) ? 24'hC0FFEE : 24'h0);
      bypass       = (j < n) ? mask[j] : 1'b0;
      step();
      if (j >= 1) begin
        od[j-1] = post_img_data;
        oh[j-1] = post_img_href;
      end
    end
  endtask

  task automatic test_reset();
    logic vs_a [6];
    logic hs_a [6];
    px_t  dt_a [6];
    logic e_vs, e_hs;
    px_t  e_d;
    rst_n = 1'b0; per_img_vsync = 1'b1; per_img_href = 1'b1;
    per_img_data = 24'h123456; bypass = 1'b1;
    repeat (10) step();
    n_cmp++; if (post_img_vsync !== 1'b0) begin n_mis++; $display("FAIL reset_vsync: got %b exp 0", post_img_vsync); end
    n_cmp++; if (post_img_href !== 1'b0) begin n_mis++; $display("FAIL reset_href: got %b exp 0", post_img_href); end
    n_cmp++; if (post_img_data !== 24'h0) begin n_mis++; $display("FAIL reset_data: got %h exp 000000", post_img_data); end
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL reset_bank: got %b exp 0", bank_active); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL reset_pending: got %b exp 0", swap_pending); end

    vs_a[0] = 1; hs_a[0] = 0; dt_a[0] = 24'hA1B2C3;
    vs_a[1] = 1; hs_a[1] = 1; dt_a[1] = 24'h00FF11;
    vs_a[2] = 1; hs_a[2] = 1; dt_a[2] = 24'h5A5A5A;
    vs_a[3] = 1; hs_a[3] = 0; dt_a[3] = 24'h777777;
    vs_a[4] = 0; hs_a[4] = 1; dt_a[4] = 24'h010203;
    vs_a[5] = 0; hs_a[5] = 1; dt_a[5] = 24'hFEDCBA;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      per_img_vsync = (j < 6) ? vs_a[j] : 1'b0;
      per_img_href  = (j < 6) ? hs_a[j] : 1'b0;
      per_img_data  = (j < 6) ? dt_a[j] : 24'h0;
      step();
      e_vs = (j == 0 || j > 6) ? 1'b0 : vs_a[j-1];
      e_hs = (j == 0 || j > 6) ? 1'b0 : hs_a[j-1];
      e_d  = (e_hs) ? dt_a[j-1] : 24'h0;
      n_cmp++; if (post_img_vsync !== e_vs) begin n_mis++; $display("FAIL lat_vsync[%0d]: got %b exp %b", j, post_img_vsync, e_vs); end
      n_cmp++; if (post_img_href !== e_hs) begin n_mis++; $display("FAIL lat_href[%0d]: got %b exp %b", j, post_img_href, e_hs); end
      n_cmp++; if (post_img_data !== e_d) begin n_mis++; $display("FAIL lat_data[%0d]: got %h exp %h", j, post_img_data, e_d); end
    end
    bypass = 1'b0;
  endtask

  task automatic test_swap_basic();
    load_lut(1'b0);
    n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL basic_idle_pending: got %b exp 0", swap_pending); end
    pulse_swap();
    n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL basic_pending: got %b exp 1", swap_pending); end
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL basic_bank_before: got %b exp 0", bank_active); end
    frame(1'b1);
    n_cmp++; if (bank_active !== 1'b1) begin n_mis++; $display("FAIL basic_bank_after: got %b exp 1", bank_active); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL basic_pending_clr: got %b exp 0", swap_pending); end

    load_lut(1'b1);
    px[0] = 24'h101010; px[1] = 24'h102030;
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'h101010) begin n_mis++; $display("FAIL ident_px0: got %h exp 101010", od[0]); end
    n_cmp++; if (od[1] !== 24'h102030) begin n_mis++; $display("FAIL ident_px1: got %h exp 102030", od[1]); end
    n_cmp++; if (od[2] !== 24'h0 || oh[2] !== 1'b0) begin n_mis++; $display("FAIL ident_gap: got %b/%h exp 0/000000", oh[2], od[2]); end

    frame(1'b0);
    pulse_swap();
    frame(1'b1);
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL inv_bank: got %b exp 0", bank_active); end
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'hEFEFEF) begin n_mis++; $display("FAIL inv_px0: got %h exp efefef", od[0]); end
    n_cmp++; if (od[1] !== 24'hEFDFCF) begin n_mis++; $display("FAIL inv_px1: got %h exp efdfcf", od[1]); end
  endtask

  task automatic test_swap_mid_frame();
    px[0] = 24'h202020; px[1] = 24'h000000;
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'hDFDFDF) begin n_mis++; $display("FAIL mid_pre_px0: got %h exp dfdfdf", od[0]); end
    n_cmp++; if (od[1] !== 24'hFFFFFF) begin n_mis++; $display("FAIL mid_pre_px1: got %h exp ffffff", od[1]); end
    pulse_swap();
    n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL mid_pending: got %b exp 1", swap_pending); end
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL mid_bank_hold: got %b exp 0", bank_active); end
    px[0] = 24'h202020; px[1] = 24'h112233;
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'hDFDFDF) begin n_mis++; $display("FAIL mid_old_px0: got %h exp dfdfdf", od[0]); end
    n_cmp++; if (od[1] !== 24'hEEDDCC) begin n_mis++; $display("FAIL mid_old_px1: got %h exp eeddcc", od[1]); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL mid_still_pending: got %b exp 1", swap_pending); end
    frame(1'b0);
    frame(1'b1);
    n_cmp++; if (bank_active !== 1'b1) begin n_mis++; $display("FAIL mid_bank_flip: got %b exp 1", bank_active); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL mid_pending_clr: got %b exp 0", swap_pending); end
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'h202020) begin n_mis++; $display("FAIL mid_new_px0: got %h exp 202020", od[0]); end
    n_cmp++; if (od[1] !== 24'h112233) begin n_mis++; $display("FAIL mid_new_px1: got %h exp 112233", od[1]); end
  endtask

  task automatic test_swap_same_cycle();
    frame(1'b0);
    swap_req = 1'b1;
    frame(1'b1);
    swap_req = 1'b0;
    n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL same_pending: got %b exp 0", swap_pending); end
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL same_bank: got %b exp 0", bank_active); end
    frame(1'b0);
    swap_req = 1'b1;
    frame(1'b0);
    frame(1'b0);
    swap_req = 1'b0;
    n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL double_pending: got %b exp 1", swap_pending); end
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL double_bank_hold: got %b exp 0", bank_active); end
    frame(1'b1);
    n_cmp++; if (bank_active !== 1'b1) begin n_mis++; $display("FAIL double_one_toggle: got %b exp 1", bank_active); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL double_pending_clr: got %b exp 0", swap_pending); end
    frame(1'b0);
    frame(1'b1);
    n_cmp++; if (bank_active !== 1'b1) begin n_mis++; $display("FAIL double_no_second: got %b exp 1", bank_active); end
  endtask

  task automatic test_bypass();
    px_t e;
    frame(1'b0);
    swap_req = 1'b1;
    frame(1'b1);
    swap_req = 1'b0;
    n_cmp++; if (bank_active !== 1'b0) begin n_mis++; $display("FAIL byp_bank: got %b exp 0", bank_active); end
    for (int i = 0; i < 8; i++) px[i] = 24'h0A1B2C + 24'(i) * 24'h101010;
    send_line(8, 8'b1111_1000);
    for (int i = 0; i < 8; i++) begin
      e = (i < 3) ? (px[i] ^ 24'hFFFFFF) : px[i];
      n_cmp++; if (od[i] !== e || oh[i] !== 1'b1) begin n_mis++; $display("FAIL byp_px%0d: got %b/%h exp 1/%h", i, oh[i], od[i], e); end
    end
    n_cmp++; if (od[8] !== 24'h0 || oh[8] !== 1'b0) begin n_mis++; $display("FAIL byp_gap: got %b/%h exp 0/000000", oh[8], od[8]); end
  endtask

  task automatic test_bad_ch_and_reset();
    px_t tbl [16];
    tbl = '{24'h000000, 24'hFFFFFF, 24'h00AA55, 24'h123456,
            24'h010101, 24'hFEFEFE, 24'h807F00, 24'hABCDEF,
            24'h00FF00, 24'h3C3C3C, 24'h0000AA, 24'h55AA55,
            24'hC3A591, 24'h7F8081, 24'h000001, 24'hAA0000};
    lut_wr_en = 1'b1; lut_wr_ch = 2'd3; lut_wr_addr = 8'h00; lut_wr_data = 8'hAA;
    step();
    lut_wr_en = 1'b0;
    frame(1'b0);
    pulse_swap();
    frame(1'b1);
    n_cmp++; if (bank_active !== 1'b1) begin n_mis++; $display("FAIL badch_bank: got %b exp 1", bank_active); end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) px[c] = tbl[r*4+c];
      send_line(4, 8'h00);
      for (int c = 0; c < 4; c++) begin
        n_cmp++; if (od[c] !== tbl[r*4+c]) begin n_mis++; $display("FAIL frame_r%0dc%0d: got %h exp %h", r, c, od[c], tbl[r*4+c]); end
      end
    end

    per_img_href = 1'b1; per_img_data = 24'h445566; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_cmp++; if (post_img_href !== 1'b0 || post_img_data !== 24'h0 || post_img_vsync !== 1'b0)
      begin n_mis++; $display("FAIL midrst_out: got %b/%b/%h exp 0/0/000000", post_img_vsync, post_img_href, post_img_data); end
    n_cmp++; if (bank_active !== 1'b0 || swap_pending !== 1'b0)
      begin n_mis++; $display("FAIL midrst_state: got bank %b pend %b exp 0 0", bank_active, swap_pending); end
    rst_n = 1'b1;
    px[0] = 24'h000000; px[1] = 24'h0F0F0F;
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'hFFFFFF) begin n_mis++; $display("FAIL keep_b0_px0: got %h exp ffffff", od[0]); end
    n_cmp++; if (od[1] !== 24'hF0F0F0) begin n_mis++; $display("FAIL keep_b0_px1: got %h exp f0f0f0", od[1]); end
    frame(1'b0);
    pulse_swap();
    frame(1'b1);
    px[0] = 24'h000000; px[1] = 24'h3C3C3C;
    send_line(2, 8'h00);
    n_cmp++; if (od[0] !== 24'h000000) begin n_mis++; $display("FAIL keep_b1_px0: got %h exp 000000", od[0]); end
    n_cmp++; if (od[1] !== 24'h3C3C3C) begin n_mis++; $display("FAIL keep_b1_px1: got %h exp 3c3c3c", od[1]); end
  endtask

  initial begin
    rst_n = 1'b0; per_img_vsync = 1'b0; per_img_href = 1'b0; per_img_data = '0;
    bypass = 1'b0; lut_wr_en = 1'b0; lut_wr_ch = '0; lut_wr_addr = '0;
    lut_wr_data = '0; swap_req = 1'b0;
    test_reset();
    test_swap_basic();
    test_swap_mid_frame();
    test_swap_same_cycle();
    test_bypass();
    test_bad_ch_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
